// File: rtl/wb_redirect_ctrl_pkg.sv
// Shared constants and types for the writeback / redirect stage.
package wb_redirect_ctrl_pkg;

   localparam int CPU_DATA_W = 32;
   localparam int CPU_REG_AW = 6;

   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_redirect_ctrl_if.sv
// EX/WB bundle in, register-file write port and PC redirect out.
interface wb_redirect_ctrl_if
   import wb_redirect_ctrl_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int REG_AW = CPU_REG_AW,
   parameter int CNT_W  = 16
) ();

   logic              valid_in;
   logic              n_in;
   logic              z_in;
   logic              mem_to_reg;
   logic              reg_wrt;
   logic              branch_z;
   logic              branch_n;
   logic              jump;
   logic              jump_mem;
   logic              pc_to_reg;
   logic [DATA_W-1:0] mem_out;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] pc_y;
   logic [REG_AW-1:0] rd;

   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              pc_redirect;
   logic [DATA_W-1:0] pc_target;
   logic              squashing;
   logic [CNT_W-1:0]  retired_cnt;
   logic [CNT_W-1:0]  squashed_cnt;

   // Pipeline side that produces the bundle and observes the results.
   modport master (
      output valid_in, n_in, z_in, mem_to_reg, reg_wrt, branch_z, branch_n,
             jump, jump_mem, pc_to_reg, mem_out, alu_out, pc_y, rd,
      input  rf_we, rf_waddr, rf_wdata, pc_redirect, pc_target, squashing,
             retired_cnt, squashed_cnt
   );

   // Writeback controller side.
   modport slave (
      input  valid_in, n_in, z_in, mem_to_reg, reg_wrt, branch_z, branch_n,
             jump, jump_mem, pc_to_reg, mem_out, alu_out, pc_y, rd,
      output rf_we, rf_waddr, rf_wdata, pc_redirect, pc_target, squashing,
             retired_cnt, squashed_cnt
   );

endinterface

// File: rtl/wb_redirect_ctrl_wb_mux.sv
// Writeback data selector: link value over memory data over ALU result.
module wb_redirect_ctrl_wb_mux
   import wb_redirect_ctrl_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W
) (
   input  logic              pc_to_reg,
   input  logic              mem_to_reg,
   input  logic [DATA_W-1:0] pc_y,
   input  logic [DATA_W-1:0] mem_out,
   input  logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] wdata
);

   // Fixed-priority source select.
   always_comb begin
      wdata = alu_out;
      if (pc_to_reg) begin
         wdata = pc_y;
      end else if (mem_to_reg) begin
         wdata = mem_out;
      end
   end

endmodule

// File: rtl/wb_redirect_ctrl.sv
// Writeback and control-transfer resolution with wrong-path squash.
module wb_redirect_ctrl
   import wb_redirect_ctrl_pkg::*;
#(
   parameter int DATA_W       = CPU_DATA_W,
   parameter int REG_AW       = CPU_REG_AW,
   parameter int FLUSH_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input logic              clk,
   input logic              rst,
   wb_redirect_ctrl_if.slave bus
);

   localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

   wb_state_e         state_q, state_d;
   logic [FLUSH_W-1:0] flush_q, flush_d;
   logic              rf_we_q, rf_we_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic              pc_redirect_q, pc_redirect_d;
   logic [DATA_W-1:0] pc_target_q, pc_target_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic [CNT_W-1:0]  squashed_q, squashed_d;

   logic [DATA_W-1:0] wb_data;
   logic              taken;

   wb_redirect_ctrl_wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
      .pc_to_reg  (bus.pc_to_reg),
      .mem_to_reg (bus.mem_to_reg),
      .pc_y       (bus.pc_y),
      .mem_out    (bus.mem_out),
      .alu_out    (bus.alu_out),
      .wdata      (wb_data)
   );

   assign taken = bus.jump | (bus.branch_z & bus.z_in) | (bus.branch_n & bus.n_in);

   // Next-state and output decode; data inputs are only looked at when valid_in
   // is high, so bubbles carrying garbage never reach any register.
   always_comb begin
      state_d       = state_q;
      flush_d       = flush_q;
      rf_we_d       = 1'b0;
      rf_waddr_d    = rf_waddr_q;
      rf_wdata_d    = rf_wdata_q;
      pc_redirect_d = 1'b0;
      pc_target_d   = pc_target_q;
      retired_d     = retired_q;
      squashed_d    = squashed_q;
      case (state_q)
         RUN: begin
            if (bus.valid_in) begin
               rf_we_d    = bus.reg_wrt;
               rf_waddr_d = bus.rd;
               rf_wdata_d = wb_data;
               retired_d  = retired_q + CNT_W'(1);
               if (taken) begin
                  pc_redirect_d = 1'b1;
                  pc_target_d   = bus.jump_mem ? bus.mem_out : bus.alu_out;
                  state_d       = SQUASH;
                  flush_d       = FLUSH_W'(FLUSH_CYCLES);
               end
            end
         end
         SQUASH: begin
            // Only real bundles count toward the flush; bubbles just wait.
            if (bus.valid_in) begin
               squashed_d = squashed_q + CNT_W'(1);
               flush_d    = flush_q - FLUSH_W'(1);
               if (flush_q == FLUSH_W'(1)) begin
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = RUN;
            flush_d = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         flush_q       <= '0;
         rf_we_q       <= 1'b0;
         rf_waddr_q    <= '0;
         rf_wdata_q    <= '0;
         pc_redirect_q <= 1'b0;
         pc_target_q   <= '0;
         retired_q     <= '0;
         squashed_q    <= '0;
      end else begin
         state_q       <= state_d;
         flush_q       <= flush_d;
         rf_we_q       <= rf_we_d;
         rf_waddr_q    <= rf_waddr_d;
         rf_wdata_q    <= rf_wdata_d;
         pc_redirect_q <= pc_redirect_d;
         pc_target_q   <= pc_target_d;
         retired_q     <= retired_d;
         squashed_q    <= squashed_d;
      end
   end

   assign bus.rf_we        = rf_we_q;
   assign bus.rf_waddr     = rf_waddr_q;
   assign bus.rf_wdata     = rf_wdata_q;
   assign bus.pc_redirect  = pc_redirect_q;
   assign bus.pc_target    = pc_target_q;
   assign bus.squashing    = (state_q == SQUASH);
   assign bus.retired_cnt  = retired_q;
   assign bus.squashed_cnt = squashed_q;

endmodule

// File: tb/tb_wb_redirect_ctrl.sv
// Bench for wb_redirect_ctrl: directed plan items plus randomized traffic
// against a bundle-level reference model.
module tb_wb_redirect_ctrl;

   localparam int DATA_W = 32;
   localparam int REG_AW = 6;
   localparam int FLUSH  = 3;
   localparam int CNT_W  = 16;

   typedef struct {
      bit              v, n, z, m2r, rw, bz, bn, j, jm, p2r;
      bit [DATA_W-1:0] mem, alu, pcy;
      bit [REG_AW-1:0] rd;
   } bundle_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_redirect_ctrl_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   wb_redirect_ctrl #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: squash window as a count of real bundles still to drop.
   bit              m_squash;
   int              m_left;
   bit              e_we, e_redir;
   bit [REG_AW-1:0] e_waddr;
   bit [DATA_W-1:0] e_wdata, e_target;
   int              e_retired, e_squashed;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model(input bundle_t b, input bit r);
      bit tk;
      if (r) begin
         m_squash = 0; m_left = 0; e_we = 0; e_redir = 0;
         e_waddr = '0; e_wdata = '0; e_target = '0;
         e_retired = 0; e_squashed = 0;
         return;
      end
      e_we = 0;
      e_redir = 0;
      if (!b.v) return;
      if (m_squash) begin
         e_squashed = (e_squashed + 1) % (1 << CNT_W);
         m_left = m_left - 1;
         if (m_left == 0) m_squash = 0;
         return;
      end
      e_we      = b.rw;
      e_waddr   = b.rd;
      e_wdata   = b.p2r ? b.pcy : (b.m2r ? b.mem : b.alu);
      e_retired = (e_retired + 1) % (1 << CNT_W);
      tk = b.j || (b.bz && b.z) || (b.bn && b.n);
      if (tk) begin
         e_redir  = 1;
         e_target = b.jm ? b.mem : b.alu;
         m_squash = 1;
         m_left   = FLUSH;
      end
   endtask

   task automatic drive(input bundle_t b);
      bus.valid_in   = b.v;   bus.n_in      = b.n;   bus.z_in     = b.z;
      bus.mem_to_reg = b.m2r; bus.reg_wrt   = b.rw;  bus.branch_z = b.bz;
      bus.branch_n   = b.bn;  bus.jump      = b.j;   bus.jump_mem = b.jm;
      bus.pc_to_reg  = b.p2r; bus.mem_out   = b.mem; bus.alu_out  = b.alu;
      bus.pc_y       = b.pcy; bus.rd        = b.rd;
   endtask

   // One clock: drive bundle, advance model, compare every output.
   task automatic step(input bundle_t b, input bit r);
      rst = r;
      drive(b);
      @(posedge clk);
      model(b, r);
      #1;
      chk("rf_we",        bus.rf_we,        e_we);
      chk("rf_waddr",     bus.rf_waddr,     e_waddr);
      chk("rf_wdata",     bus.rf_wdata,     e_wdata);
      chk("pc_redirect",  bus.pc_redirect,  e_redir);
      chk("pc_target",    bus.pc_target,    e_target);
      chk("squashing",    bus.squashing,    m_squash);
      chk("retired_cnt",  bus.retired_cnt,  e_retired[CNT_W-1:0]);
      chk("squashed_cnt", bus.squashed_cnt, e_squashed[CNT_W-1:0]);
   endtask

   function automatic bundle_t idle();
      bundle_t b;
      b = '{default: 0};
      return b;
   endfunction

   function automatic bundle_t alu_op(input bit [REG_AW-1:0] rd, input bit [DATA_W-1:0] v);
      bundle_t b;
      b = idle();
      b.v = 1; b.rw = 1; b.rd = rd; b.alu = v;
      return b;
   endfunction

   function automatic bundle_t rnd_bundle();
      bundle_t b;
      b.v   = ($urandom_range(0, 3) != 0);
      b.n   = 1'($urandom);  b.z  = 1'($urandom);
      b.m2r = 1'($urandom);  b.rw = 1'($urandom);
      b.bz  = ($urandom_range(0, 5) == 0);
      b.bn  = ($urandom_range(0, 5) == 0);
      b.j   = ($urandom_range(0, 9) == 0);
      b.jm  = 1'($urandom);  b.p2r = ($urandom_range(0, 3) == 0);
      b.mem = $urandom; b.alu = $urandom; b.pcy = $urandom;
      b.rd  = REG_AW'($urandom);
      return b;
   endfunction

   initial begin
      bundle_t b;
      drive(idle());
      // Reset state
      step(rnd_bundle(), 1);
      step(idle(), 1);
      chk("rst_we",      bus.rf_we,       1'b0);
      chk("rst_retired", bus.retired_cnt, 16'd0);
      chk("rst_target",  bus.pc_target,   32'd0);

      // Plain ALU writeback
      step(alu_op(6'd5, 32'h2A), 0);
      chk("alu_we",      bus.rf_we,       1'b1);
      chk("alu_waddr",   bus.rf_waddr,    6'd5);
      chk("alu_wdata",   bus.rf_wdata,    32'h2A);
      chk("alu_retired", bus.retired_cnt, 16'd1);

      // Load, then link value overriding the load
      b = alu_op(6'd7, 32'h10); b.m2r = 1; b.mem = 32'hDEAD_BEEF;
      step(b, 0);
      chk("load_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
      b.p2r = 1; b.pcy = 32'h21;
      step(b, 0);
      chk("link_wdata", bus.rf_wdata, 32'h21);

      // Taken branch_z, three squashed bundles, fourth accepted
      b = idle(); b.v = 1; b.bz = 1; b.z = 1; b.alu = 32'h40;
      step(b, 0);
      chk("bz_redirect",  bus.pc_redirect, 1'b1);
      chk("bz_target",    bus.pc_target,   32'h40);
      chk("bz_squashing", bus.squashing,   1'b1);
      step(alu_op(6'd1, 32'h11), 0);
      chk("bz_pulse_once", bus.pc_redirect, 1'b0);
      step(alu_op(6'd2, 32'h12), 0);
      step(alu_op(6'd3, 32'h13), 0);
      chk("sq_squashed", bus.squashed_cnt, 16'd3);
      chk("sq_we",       bus.rf_we,        1'b0);
      step(alu_op(6'd4, 32'h14), 0);
      chk("sq_accept",   bus.rf_we,        1'b1);

      // Squash with bubbles interleaved
      b = idle(); b.v = 1; b.j = 1; b.alu = 32'h44;
      step(b, 0);
      step(alu_op(6'd1, 32'h1), 0);
      b = rnd_bundle(); b.v = 0; step(b, 0);
      b = rnd_bundle(); b.v = 0; step(b, 0);
      step(alu_op(6'd2, 32'h2), 0);
      chk("bub_still_sq", bus.squashing, 1'b1);
      step(alu_op(6'd3, 32'h3), 0);
      chk("bub_exit", bus.squashing, 1'b0);
      step(alu_op(6'd9, 32'h99), 0);
      chk("bub_accept", bus.rf_we, 1'b1);

      // Not-taken branches hold the target; jump via memory
      b = idle(); b.v = 1; b.bn = 1; b.n = 0; b.alu = 32'h123;
      step(b, 0);
      b.bn = 0; b.bz = 1; b.z = 0; b.n = 1;
      step(b, 0);
      chk("nt_redirect", bus.pc_redirect, 1'b0);
      chk("nt_hold",     bus.pc_target,   32'h44);
      b = idle(); b.v = 1; b.j = 1; b.jm = 1; b.mem = 32'h80; b.alu = 32'h55;
      b.rw = 1; b.p2r = 1; b.pcy = 32'h77; b.rd = 6'd31;
      step(b, 0);
      chk("jm_target", bus.pc_target, 32'h80);
      chk("jal_we",    bus.rf_we,     1'b1);
      chk("jal_wdata", bus.rf_wdata,  32'h77);

      // Reset in the middle of a squash
      step(alu_op(6'd1, 32'h1), 0);
      step(alu_op(6'd2, 32'h2), 1);
      chk("rsq_squashing", bus.squashing,    1'b0);
      chk("rsq_squashed",  bus.squashed_cnt, 16'd0);
      chk("rsq_we",        bus.rf_we,        1'b0);
      step(alu_op(6'd6, 32'h66), 0);
      chk("rsq_accept", bus.rf_we, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) step(rnd_bundle(), ($urandom_range(0, 199) == 0));

      // Retired counter wrap
      step(idle(), 1);
      for (int i = 0; i < (1 << CNT_W); i++) step(alu_op(6'(i), 32'(i)), 0);
      chk("wrap_retired", bus.retired_cnt, 16'd0);
      step(alu_op(6'd0, 32'h0), 0);
      chk("wrap_plus1", bus.retired_cnt, 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
